// File: rtl/riscv_div_unit.sv
// riscv_div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle over magnitudes, sign fix-up on the final iteration.
// Optional macro RISCV_DIV_FASTPATH_EN: divide-by-zero and signed overflow are
// resolved at accept and complete one cycle later instead of iterating.
module riscv_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SIGN_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;

  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;

  logic             r_rem_sel;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic             r_ovf;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_div_zero_in;
  logic             w_ovf_in;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_final;

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign result_o    = r_result;

  // Operand decode: signs, magnitudes and the two architectural corner cases
  assign w_a_neg       = op_i[0] & opa_i[WIDTH-1];
  assign w_b_neg       = op_i[0] & opb_i[WIDTH-1];
  assign w_a_mag       = w_a_neg ? (~opa_i + WIDTH'(1)) : opa_i;
  assign w_b_mag       = w_b_neg ? (~opb_i + WIDTH'(1)) : opb_i;
  assign w_div_zero_in = (opb_i == '0);
  assign w_ovf_in      = op_i[0] & (opa_i == SIGN_MIN) & (opb_i == '1);

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_divisor};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == LAST_ITER);

  // Sign restoration of the magnitude results
  assign w_quo_fix = r_neg_q ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;

  // Final result select with divide-by-zero and overflow overrides
  always_comb begin
    w_final = r_rem_sel ? w_rem_fix : w_quo_fix;
    if (r_div_zero) begin
      w_final = r_rem_sel ? r_opa : '1;
    end else if (r_ovf) begin
      w_final = r_rem_sel ? '0 : r_opa;
    end
  end

`ifdef RISCV_DIV_FASTPATH_EN
  logic             w_special_in;
  logic [WIDTH-1:0] w_fast_res;

  assign w_special_in = w_div_zero_in | w_ovf_in;

  // Immediate result for corner cases that skip the iteration
  always_comb begin
    w_fast_res = '0;
    if (op_i[1]) begin
      w_fast_res = w_div_zero_in ? opa_i : '0;
    end else begin
      w_fast_res = w_div_zero_in ? '1 : opa_i;
    end
  end
`endif

  // Next-state logic; flush overrides accept and output handshake
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            w_accept = 1'b1;
`ifdef RISCV_DIV_FASTPATH_EN
            w_state_nxt = w_special_in ? DONE : CALC;
`else
            w_state_nxt = CALC;
`endif
          end
        end
        CALC: begin
          if (w_last) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (r_out_valid && out_ready_i) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register and registered status outputs decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Datapath: capture operands on accept, iterate in CALC, load result at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem_sel  <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_opa      <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_rem_sel  <= op_i[1];
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_div_zero <= w_div_zero_in;
      r_ovf      <= w_ovf_in;
      r_opa      <= opa_i;
      r_divisor  <= w_b_mag;
      r_quo      <= w_a_mag;
      r_rem      <= '0;
      r_cnt      <= '0;
`ifdef RISCV_DIV_FASTPATH_EN
      if (w_special_in) begin
        r_result <= w_fast_res;
      end
`endif
    end else if ((r_state == CALC) && !flush_i) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb_riscv_div_unit: randomized and directed checks of riscv_div_unit against
// a plain-arithmetic division model, for a 32-bit and an 8-bit instance.
`timescale 1ns/1ps
module tb_riscv_div_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;
`ifdef RISCV_DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [1:0] DIVU = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] REMU = 2'd2;
  localparam logic [1:0] REM  = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          flush = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  logic          flush8 = 1'b0;
  logic [1:0]    op8 = '0;
  logic [W8-1:0] opa8 = '0;
  logic [W8-1:0] opb8 = '0;
  logic          in_valid8 = 1'b0;
  logic          in_ready8;
  logic [W8-1:0] result8;
  logic          out_valid8;
  logic          out_ready8 = 1'b0;
  logic          busy8;

  int            total = 0;
  int            bad = 0;
  logic          exp_set = 1'b0;
  logic [63:0]   exp_res = '0;
  logic          exp_set8 = 1'b0;
  logic [63:0]   exp_res8 = '0;

  riscv_div_unit #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .op_i(op), .opa_i(opa), .opb_i(opb),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .result_o(result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  riscv_div_unit #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst(rst), .flush_i(flush8), .op_i(op8), .opa_i(opa8), .opb_i(opb8),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8), .result_o(result8),
    .out_valid_o(out_valid8), .out_ready_i(out_ready8), .busy_o(busy8)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension division semantics in plain 64-bit arithmetic
  function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = $signed(a << (64 - w)) >>> (64 - w);
    sb   = $signed(b << (64 - w)) >>> (64 - w);
    if (b == 64'd0) begin
      q = -1;
      r = sa;
    end else if (o[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(a / b);
      r = longint'(a % b);
    end
    return (o[1] ? 64'(r) : 64'(q)) & mask;
  endfunction

  function automatic int lat_for(input int w, input logic [1:0] o,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic [63:0] smin;
    mask = (64'd1 << w) - 64'd1;
    smin = 64'd1 << (w - 1);
    if (FAST && (((b & mask) == 64'd0) ||
                 (o[0] && ((a & mask) == smin) && ((b & mask) == mask))))
      return 1;
    return w + 1;
  endfunction

  // Compare process: every cycle, a pending result must match the model,
  // and no valid may appear without a pending request
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_set) begin
        if (out_valid) begin
          check("result32", 64'(result), exp_res);
          check("in_ready32_in_done", 64'(in_ready), 64'd0);
        end
      end else begin
        check("spurious_valid32", 64'(out_valid), 64'd0);
      end
      if (exp_set8) begin
        if (out_valid8) check("result8", 64'(result8), exp_res8);
      end else begin
        check("spurious_valid8", 64'(out_valid8), 64'd0);
      end
    end
  end

  // From just after the accept edge: wait for valid, hold, then handshake
  task automatic finish_op(input string name, input int exp_lat, input bit use_lit,
                           input logic [31:0] lit, input int hold);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (use_lit) check({name, "_value"}, 64'(result), 64'(lit));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_busy"}, 64'(busy), 64'd1);
    end
    if (use_lit && hold > 0) check({name, "_hold_value"}, 64'(result), 64'(lit));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_set   = 1'b0;
    check({name, "_ready_after"}, 64'(in_ready), 64'd1);
    check({name, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit use_lit, input logic [31:0] lit,
                        input int hold);
    @(negedge clk);
    check({name, "_ready_before"}, 64'(in_ready), 64'd1);
    op = o; opa = a; opb = b; in_valid = 1'b1;
    exp_res = model(W, o, 64'(a), 64'(b));
    exp_set = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); opa = $urandom; opb = $urandom;
    finish_op(name, lat_for(W, o, 64'(a), 64'(b)), use_lit, lit, hold);
  endtask

  task automatic run8(input string name, input logic [1:0] o, input logic [7:0] a,
                      input logic [7:0] b, input bit use_lit, input logic [7:0] lit);
    int lat;
    @(negedge clk);
    op8 = o; opa8 = a; opb8 = b; in_valid8 = 1'b1;
    exp_res8 = model(W8, o, 64'(a), 64'(b));
    exp_set8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    opa8 = 8'($urandom); opb8 = 8'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(lat_for(W8, o, 64'(a), 64'(b))));
    if (use_lit) check({name, "_value"}, 64'(result8), 64'(lit));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    exp_set8   = 1'b0;
    check({name, "_ready_after"}, 64'(in_ready8), 64'd1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          fl;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-computed results
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 0);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 1'b1, 32'd2, 0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 0);
    run_op("divu_5_0", DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0", REMU, 32'd5, 32'd0, 1'b1, 32'd5, 0);
    run_op("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 0);
    run_op("rem_m5_0", REM, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 0);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 0);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 0);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 0);

    // Backpressure: result held stable while consumer stalls
    run_op("stall10", DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 10);

    // Flush in IDLE with a request present: nothing is accepted
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = DIVU; opa = 32'd9; opb = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_ready", 64'(in_ready), 64'd1);

    // Flush at CALC cycle 15 with a new request pending, then accept it
    @(negedge clk);
    op = DIVU; opa = 32'd1000; opb = 32'd3; in_valid = 1'b1;
    exp_res = model(W, DIVU, 64'd1000, 64'd3);
    exp_set = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = DIV; opa = 32'hFFFF_FFF9; opb = 32'd2;
    @(posedge clk); #1;
    flush   = 1'b0;
    exp_set = 1'b0;
    check("flush_calc_ready", 64'(in_ready), 64'd1);
    check("flush_calc_valid", 64'(out_valid), 64'd0);
    check("flush_calc_busy", 64'(busy), 64'd0);
    exp_res = model(W, DIV, 64'(32'hFFFF_FFF9), 64'd2);
    exp_set = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_follow_busy", 64'(busy), 64'd1);
    finish_op("flush_follow", W + 1, 1'b1, 32'hFFFF_FFFD, 0);

    // Flush in DONE wins over the output handshake
    @(negedge clk);
    op = REMU; opa = 32'd77; opb = 32'd10; in_valid = 1'b1;
    exp_res = model(W, REMU, 64'd77, 64'd10);
    exp_set = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fl = 1;
    while (!out_valid && fl < 200) begin
      @(posedge clk); #1;
      fl++;
    end
    check("flush_done_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; exp_set = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of CALC abandons the operation
    @(negedge clk);
    op = DIVU; opa = 32'd123456; opb = 32'd789; in_valid = 1'b1;
    exp_res = model(W, DIVU, 64'd123456, 64'd789);
    exp_set = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_set = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with corner-case biasing
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ro[0] = 1'b1; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("rand32", ro, ra, rb, 1'b0, 32'd0, int'($urandom_range(0, 3)));
    end

    // 8-bit instance
    run8("w8_divu_200_3", DIVU, 8'd200, 8'd3, 1'b1, 8'd66);
    run8("w8_rem_m128_m1", REM, 8'h80, 8'hFF, 1'b1, 8'd0);
    run8("w8_div_m128_m1", DIV, 8'h80, 8'hFF, 1'b1, 8'h80);
    for (int n = 0; n < 12; n++) begin
      run8("rand8", 2'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 1'b0, 8'd0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
